costas_loop_filter: RTL and testbench

COSTAS_LOOP_FILTER -- requirements
Module: costas_loop_filter

---
 rtl/costas_loop_filter.sv | 170 +++++++++++++++++
 tb/tb_costas_loop_filter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/costas_loop_filter.sv
// rtl/costas_loop_filter.sv - Costas loop PI filter producing the NCO frequency control word, with lock detector
// Optional gain gear-shifting when locked is enabled by defining COSTAS_GEARSHIFT_EN.
module costas_loop_filter #(
   parameter int                     ERR_WIDTH   = 16,
   parameter int                     PHASE_WIDTH = 32,
   parameter int                     KP_SHIFT    = 8,
   parameter int                     KI_SHIFT    = 2,
   parameter logic [PHASE_WIDTH-1:0] FREQ_CENTER = 32'h0400_0000,
   parameter logic [PHASE_WIDTH-1:0] INT_LIMIT   = 32'h0100_0000,
   parameter int                     LOCK_THRESH = 512,
   parameter int                     LOCK_COUNT  = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ERR_WIDTH-1:0]   err_i,
   input  logic                   err_valid_i,
   input  logic                   freeze_i,
   output logic [PHASE_WIDTH-1:0] phi_inc_o,
   output logic                   phi_inc_valid_o,
   output logic                   locked_o,
   output logic                   int_sat_o
);

   localparam int AW = PHASE_WIDTH + 1;
   localparam int SW = PHASE_WIDTH + 2;
   localparam int CW = $clog2(LOCK_COUNT + 1);

   localparam logic signed [SW-1:0] LIM_POS  = SW'(INT_LIMIT);
   localparam logic signed [SW-1:0] LIM_NEG  = -LIM_POS;
   localparam logic [CW-1:0]        CNT_LAST = CW'(LOCK_COUNT - 1);
   localparam logic [ERR_WIDTH:0]   THRESH_W = (ERR_WIDTH + 1)'(LOCK_THRESH);

   typedef enum logic [1:0] {SEARCH, LOCKED, HOLD} lock_state_t;

   lock_state_t           state;
   logic [CW-1:0]         lock_cnt;

   logic signed [AW-1:0]  err_ext;
   logic signed [AW-1:0]  prop_next;
   logic signed [AW-1:0]  inc_next;
   logic signed [AW-1:0]  prop_s1;
   logic signed [AW-1:0]  inc_s1;
   logic                  s1_valid;

   logic signed [AW-1:0]  integ;
   logic signed [SW-1:0]  integ_sum;
   logic signed [AW-1:0]  integ_new;
   logic                  sat_next;
   logic [PHASE_WIDTH-1:0] phi_next;

   logic [ERR_WIDTH:0]    err_wide;
   logic [ERR_WIDTH:0]    err_abs;
   logic                  err_in;

   assign err_ext = {{(AW-ERR_WIDTH){err_i[ERR_WIDTH-1]}}, err_i};

`ifdef COSTAS_GEARSHIFT_EN
   // Narrow the loop bandwidth once locked; uses the registered lock flag so
   // the switch lands on the sample after locked_o changes.
   always_comb begin
      if (locked_o) begin
         prop_next = err_ext <<< (KP_SHIFT - 2);
         inc_next  = err_ext <<< (KI_SHIFT - 2);
      end else begin
         prop_next = err_ext <<< KP_SHIFT;
         inc_next  = err_ext <<< KI_SHIFT;
      end
   end
`else
   assign prop_next = err_ext <<< KP_SHIFT;
   assign inc_next  = err_ext <<< KI_SHIFT;
`endif

   // One extra bit so the most negative error maps to a large magnitude.
   assign err_wide = {err_i[ERR_WIDTH-1], err_i};
   assign err_abs  = err_wide[ERR_WIDTH] ? (~err_wide + 1'b1) : err_wide;
   assign err_in   = (err_abs < THRESH_W);

   assign integ_sum = {integ[AW-1], integ} + {inc_s1[AW-1], inc_s1};

   always_comb begin
      integ_new = integ;
      sat_next  = int_sat_o;
      if (!freeze_i) begin
         if (integ_sum > LIM_POS) begin
            integ_new = AW'(LIM_POS);
            sat_next  = 1'b1;
         end else if (integ_sum < LIM_NEG) begin
            integ_new = AW'(LIM_NEG);
            sat_next  = 1'b1;
         end else begin
            integ_new = AW'(integ_sum);
            sat_next  = 1'b0;
         end
      end
   end

   // Output word wraps modulo 2^PHASE_WIDTH by truncation.
   assign phi_next = PHASE_WIDTH'(AW'(FREQ_CENTER) + integ_new + prop_s1);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid        <= 1'b0;
         prop_s1         <= '0;
         inc_s1          <= '0;
         integ           <= '0;
         int_sat_o       <= 1'b0;
         phi_inc_o       <= FREQ_CENTER;
         phi_inc_valid_o <= 1'b0;
      end else begin
         s1_valid <= err_valid_i;
         if (err_valid_i) begin
            prop_s1 <= prop_next;
            inc_s1  <= inc_next;
         end
         phi_inc_valid_o <= s1_valid;
         if (s1_valid) begin
            integ     <= integ_new;
            int_sat_o <= sat_next;
            phi_inc_o <= phi_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= SEARCH;
         lock_cnt <= '0;
         locked_o <= 1'b0;
      end else if (err_valid_i) begin
         case (state)
            SEARCH: begin
               if (!err_in) begin
                  lock_cnt <= '0;
               end else if (lock_cnt == CNT_LAST) begin
                  state    <= LOCKED;
                  lock_cnt <= '0;
                  locked_o <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt + 1'b1;
               end
            end
            LOCKED: begin
               if (!err_in) begin
                  state    <= HOLD;
                  lock_cnt <= CW'(1);
               end
            end
            HOLD: begin
               if (err_in) begin
                  state    <= LOCKED;
                  lock_cnt <= '0;
               end else if (lock_cnt == CNT_LAST) begin
                  state    <= SEARCH;
                  lock_cnt <= '0;
                  locked_o <= 1'b0;
               end else begin
                  lock_cnt <= lock_cnt + 1'b1;
               end
            end
            default: begin
               state    <= SEARCH;
               lock_cnt <= '0;
               locked_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_costas_loop_filter.sv
// tb/tb_costas_loop_filter.sv - self-checking bench for costas_loop_filter
module tb_costas_loop_filter;

   localparam logic [31:0] FC  = 32'h0400_0000;
   localparam longint      LIM = 64'h0100_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] err_i = '0;
   logic        err_valid_i = 1'b0;
   logic        freeze_i = 1'b0;
   logic [31:0] phi_inc_o;
   logic        phi_inc_valid_o;
   logic        locked_o;
   logic        int_sat_o;

   int total = 0;
   int bad   = 0;

   // reference model state
   longint      m_integ;
   logic [31:0] m_phi;
   logic        m_valid, m_sat, m_locked;
   int          m_in_run, m_out_run;
   logic        m_s1_valid;
   longint      m_s1_prop, m_s1_inc;

   costas_loop_filter dut (
      .clk(clk), .reset(reset), .err_i(err_i), .err_valid_i(err_valid_i),
      .freeze_i(freeze_i), .phi_inc_o(phi_inc_o), .phi_inc_valid_o(phi_inc_valid_o),
      .locked_o(locked_o), .int_sat_o(int_sat_o)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_integ = 0; m_phi = FC; m_valid = 0; m_sat = 0; m_locked = 0;
      m_in_run = 0; m_out_run = 0; m_s1_valid = 0; m_s1_prop = 0; m_s1_inc = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; err_valid_i = 1'b0; freeze_i = 1'b0;
      @(posedge clk); @(posedge clk);
      model_reset();
      #1 reset = 1'b0;
   endtask

   // Drive one cycle of inputs, advance one clock edge and update the model.
   task automatic step(input int err, input bit v, input bit frz);
      longint sum, full;
      int kp, ki, mag;
      err_i = 16'(err); err_valid_i = v; freeze_i = frz;
      @(posedge clk);
      if (m_s1_valid) begin
         if (!frz) begin
            sum = m_integ + m_s1_inc;
            if (sum > LIM) begin m_integ = LIM; m_sat = 1; end
            else if (sum < -LIM) begin m_integ = -LIM; m_sat = 1; end
            else begin m_integ = sum; m_sat = 0; end
         end
         full = longint'(FC) + m_integ + m_s1_prop;
         m_phi = full[31:0];
      end
      m_valid = m_s1_valid;
      kp = 8; ki = 2;
`ifdef COSTAS_GEARSHIFT_EN
      if (m_locked) begin kp = 6; ki = 0; end
`endif
      m_s1_valid = v;
      if (v) begin
         m_s1_prop = longint'(err) * (longint'(1) << kp);
         m_s1_inc  = longint'(err) * (longint'(1) << ki);
         mag = (err < 0) ? -err : err;
         if (!m_locked) begin
            m_in_run = (mag < 512) ? m_in_run + 1 : 0;
            if (m_in_run == 64) begin m_locked = 1; m_in_run = 0; m_out_run = 0; end
         end else begin
            m_out_run = (mag < 512) ? 0 : m_out_run + 1;
            if (m_out_run == 64) begin m_locked = 0; m_in_run = 0; m_out_run = 0; end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) step(0, 0, 0);
      total++;
      if ({phi_inc_o, phi_inc_valid_o, locked_o, int_sat_o} !== {32'h0400_0000, 3'b000}) begin
         bad++;
         $display("FAIL reset_idle: got phi=%h v=%b lk=%b sat=%b want phi=04000000 v=0 lk=0 sat=0",
                  phi_inc_o, phi_inc_valid_o, locked_o, int_sat_o);
      end
   endtask

   task automatic test_single();
      step(100, 1, 0);
      total++;
      if (phi_inc_valid_o !== 1'b0) begin bad++; $display("FAIL single_early: valid=%b want 0", phi_inc_valid_o); end
      step(0, 0, 0);
      total++;
      if ({phi_inc_valid_o, phi_inc_o} !== {1'b1, 32'h0400_6590}) begin
         bad++; $display("FAIL single_out: valid=%b phi=%h want 1 04006590", phi_inc_valid_o, phi_inc_o);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0);
         total++;
         if ({phi_inc_valid_o, phi_inc_o} !== {1'b0, 32'h0400_6590}) begin
            bad++; $display("FAIL single_hold: valid=%b phi=%h want 0 04006590", phi_inc_valid_o, phi_inc_o);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 1; i <= 132; i++) begin
         step((i <= 129) ? 32767 : ((i == 130) ? -1 : 0), i <= 130, 0);
         total++;
         if ({phi_inc_o, phi_inc_valid_o, int_sat_o} !== {m_phi, m_valid, m_sat}) begin
            bad++; $display("FAIL sat_model[%0d]: phi=%h v=%b sat=%b want phi=%h v=%b sat=%b",
                            i, phi_inc_o, phi_inc_valid_o, int_sat_o, m_phi, m_valid, m_sat);
         end
         if (i - 1 == 128 || i - 1 == 130) begin
            total++;
            if (int_sat_o !== 1'b0) begin bad++; $display("FAIL sat_clear[%0d]: sat=%b want 0", i - 1, int_sat_o); end
         end
         if (i - 1 == 129) begin
            total++;
            if ({int_sat_o, phi_inc_o} !== {1'b1, 32'h057F_FF00}) begin
               bad++; $display("FAIL sat_hit: sat=%b phi=%h want 1 057fff00", int_sat_o, phi_inc_o);
            end
         end
      end
   endtask

   task automatic test_lock();
      do_reset();
      for (int i = 1; i <= 64; i++) begin
         step(10, 1, 0);
         total++;
         if (locked_o !== (i == 64)) begin bad++; $display("FAIL lock_rise[%0d]: locked=%b want %b", i, locked_o, i == 64); end
      end
      for (int i = 1; i <= 64; i++) begin
         step((i <= 63) ? 600 : 0, 1, 0);
         total++;
         if (locked_o !== 1'b1) begin bad++; $display("FAIL lock_hold[%0d]: locked=%b want 1", i, locked_o); end
      end
      for (int i = 1; i <= 64; i++) begin
         step(-32768, 1, 0);
         total++;
         if ({locked_o, phi_inc_o} !== {(i != 64), m_phi}) begin
            bad++; $display("FAIL lock_fall[%0d]: locked=%b phi=%h want %b %h", i, locked_o, phi_inc_o, i != 64, m_phi);
         end
      end
   endtask

   task automatic test_freeze();
      longint integ0, full;
      do_reset();
      for (int i = 0; i < 5; i++) step(-50, 1, 0);
      step(0, 0, 0); step(0, 0, 0);
      integ0 = m_integ;
      full = longint'(FC) + integ0 + 25600;
      for (int i = 0; i < 5; i++) begin
         step(100, i < 3, 1);
         if (i >= 1 && i <= 3) begin
            total++;
            if ({phi_inc_valid_o, phi_inc_o} !== {1'b1, full[31:0]}) begin
               bad++; $display("FAIL freeze[%0d]: valid=%b phi=%h want 1 %h", i, phi_inc_valid_o, phi_inc_o, full[31:0]);
            end
         end
      end
      total++;
      if (m_integ !== integ0) begin bad++; $display("FAIL freeze_integ: model integ=%0d want %0d", m_integ, integ0); end
      freeze_i = 1'b0;
   endtask

   task automatic test_random();
      int e;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 65535)) - 32768;
         else e = int'($urandom_range(0, 1400)) - 700;
         step(e, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0);
         total++;
         if ({phi_inc_o, phi_inc_valid_o, locked_o, int_sat_o} !== {m_phi, m_valid, m_locked, m_sat}) begin
            bad++; $display("FAIL random[%0d]: phi=%h v=%b lk=%b sat=%b want phi=%h v=%b lk=%b sat=%b",
                            i, phi_inc_o, phi_inc_valid_o, locked_o, int_sat_o, m_phi, m_valid, m_locked, m_sat);
         end
      end
   endtask

   task automatic test_reset_in_flight();
      step(1234, 1, 0);
      step(-500, 1, 0);
      reset = 1'b1; err_valid_i = 1'b1; err_i = 16'd77;
      @(posedge clk); #1;
      model_reset();
      total++;
      if ({phi_inc_o, phi_inc_valid_o, locked_o, int_sat_o} !== {32'h0400_0000, 3'b000}) begin
         bad++; $display("FAIL flight_reset: phi=%h v=%b lk=%b sat=%b want 04000000 0 0 0",
                         phi_inc_o, phi_inc_valid_o, locked_o, int_sat_o);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0);
         total++;
         if ({phi_inc_valid_o, phi_inc_o} !== {1'b0, 32'h0400_0000}) begin
            bad++; $display("FAIL flight_drop[%0d]: valid=%b phi=%h want 0 04000000", i, phi_inc_valid_o, phi_inc_o);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_saturation();
      test_lock();
      test_freeze();
      test_random();
      test_reset_in_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
